// File: rtl/int_ctrl_n.sv
// int_ctrl_n: MM-mapped interrupt controller with synchronised, edge/level,
// polarity-selectable channels. Optional input debounce when INTC_DEBOUNCE_EN is defined.
module int_ctrl_n #(
  parameter int unsigned MM_ADDR_WIDTH = 8,
  parameter int unsigned MM_DATA_WIDTH = 16,
  parameter int unsigned INT_NUM       = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEB_CYCLES    = 4,
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_PND  = MM_ADDR_WIDTH'('h04),
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_CLR  = MM_ADDR_WIDTH'('h06),
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_MSK  = MM_ADDR_WIDTH'('h08),
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_MODE = MM_ADDR_WIDTH'('h0A),
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_POL  = MM_ADDR_WIDTH'('h0C),
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_ID   = MM_ADDR_WIDTH'('h0E),
  parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_INT_RAW  = MM_ADDR_WIDTH'('h10)
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic [MM_ADDR_WIDTH-1:0] mm_s_addr_i,
  input  logic [MM_DATA_WIDTH-1:0] mm_s_wdata_i,
  output logic [MM_DATA_WIDTH-1:0] mm_s_rdata_o,
  input  logic                     mm_s_we_i,
  input  logic [INT_NUM-1:0]       int_i,
  output logic                     sys_int_o
);

  if (INT_NUM < 1 || INT_NUM > MM_DATA_WIDTH - 1) begin : g_bad_int_num
    $error("int_ctrl_n: INT_NUM out of range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("int_ctrl_n: SYNC_STAGES must be at least 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("int_ctrl_n: DEB_CYCLES must be at least 1");
  end

  logic wr_clr, wr_msk, wr_mode, wr_pol, cfg_wr, sup_c, sup_q, gie_n_q;
  logic [INT_NUM-1:0] sync_q [SYNC_STAGES];
  logic [INT_NUM-1:0] samp_q, act, flt, flt_d, edge_det;
  logic [INT_NUM-1:0] msk_q, mode_q, pol_q, clr_q, pnd_q, pnd_nxt;
  logic [MM_DATA_WIDTH-1:0] id_c, rdata_c;
  logic unused_wdata;

  assign wr_clr  = mm_s_we_i && (mm_s_addr_i == REG_ADDR_INT_CLR);
  assign wr_msk  = mm_s_we_i && (mm_s_addr_i == REG_ADDR_INT_MSK);
  assign wr_mode = mm_s_we_i && (mm_s_addr_i == REG_ADDR_INT_MODE);
  assign wr_pol  = mm_s_we_i && (mm_s_addr_i == REG_ADDR_INT_POL);
  assign cfg_wr  = wr_mode || wr_pol;
  assign sup_c   = cfg_wr || sup_q;
  assign unused_wdata = ^mm_s_wdata_i;

  // Synchroniser plus a sample stage; raw (un-normalised) values so a POL change alone never looks like an edge
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      samp_q <= '1;
    end else begin
      sync_q[0] <= int_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      samp_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign act = samp_q ^ ~pol_q;

`ifdef INTC_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES) + 1;
  logic [CNT_W-1:0]   cnt_q [INT_NUM];
  logic [INT_NUM-1:0] flt_q, flt_d_q, pol_delta;

  // Polarity writes flip the filtered state in place so a POL change is not seen as a transition
  assign pol_delta = wr_pol ? (mm_s_wdata_i[INT_NUM-1:0] ^ pol_q) : '0;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < INT_NUM; k++) cnt_q[k] <= '0;
      flt_q   <= '0;
      flt_d_q <= '0;
    end else begin
      for (int k = 0; k < INT_NUM; k++) begin
        if (act[k] == flt_q[k]) begin
          cnt_q[k] <= '0;
          flt_q[k] <= flt_q[k] ^ pol_delta[k];
        end else if (cnt_q[k] == CNT_W'(DEB_CYCLES - 1)) begin
          cnt_q[k] <= '0;
          flt_q[k] <= act[k] ^ pol_delta[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
          flt_q[k] <= flt_q[k] ^ pol_delta[k];
        end
      end
      flt_d_q <= flt_q ^ pol_delta;
    end
  end

  assign flt   = flt_q;
  assign flt_d = flt_d_q;
`else
  logic [INT_NUM-1:0] hist_q;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) hist_q <= '1;
    else          hist_q <= samp_q;
  end

  assign flt   = act;
  assign flt_d = hist_q ^ ~pol_q;
`endif

  // Configuration registers; CLR is a one-cycle pulse register
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      msk_q   <= '1;
      gie_n_q <= 1'b1;
      mode_q  <= '0;
      pol_q   <= '0;
      clr_q   <= '0;
      sup_q   <= 1'b0;
    end else begin
      if (wr_msk) begin
        msk_q   <= mm_s_wdata_i[INT_NUM-1:0];
        gie_n_q <= mm_s_wdata_i[MM_DATA_WIDTH-1];
      end
      if (wr_mode) mode_q <= mm_s_wdata_i[INT_NUM-1:0];
      if (wr_pol)  pol_q  <= mm_s_wdata_i[INT_NUM-1:0];
      clr_q <= wr_clr ? mm_s_wdata_i[INT_NUM-1:0] : '0;
      sup_q <= cfg_wr;
    end
  end

  // Edge channels: set beats clear; level channels follow the asserted input
  always_comb begin
    edge_det = flt & ~flt_d & ~{INT_NUM{sup_c}};
    pnd_nxt  = (pnd_q & ~clr_q) | (edge_det & ~msk_q);
    pnd_nxt  = (pnd_nxt & ~mode_q) | (flt & ~msk_q & mode_q);
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pnd_q     <= '0;
      sys_int_o <= 1'b1;
    end else begin
      pnd_q     <= pnd_nxt;
      sys_int_o <= ~(|pnd_q) | gie_n_q;
    end
  end

  // Lowest-numbered pending channel wins
  always_comb begin
    id_c = '0;
    for (int k = INT_NUM - 1; k >= 0; k--) begin
      if (pnd_q[k]) id_c = MM_DATA_WIDTH'(k + 1);
    end
  end

  always_comb begin
    rdata_c = '0;
    if (rst_n_i) begin
      case (mm_s_addr_i)
        REG_ADDR_INT_PND:  rdata_c[INT_NUM-1:0] = pnd_q;
        REG_ADDR_INT_MSK: begin
          rdata_c[INT_NUM-1:0]       = msk_q;
          rdata_c[MM_DATA_WIDTH-1]   = gie_n_q;
        end
        REG_ADDR_INT_MODE: rdata_c[INT_NUM-1:0] = mode_q;
        REG_ADDR_INT_POL:  rdata_c[INT_NUM-1:0] = pol_q;
        REG_ADDR_INT_ID:   rdata_c = id_c;
        REG_ADDR_INT_RAW:  rdata_c[INT_NUM-1:0] = act;
        default: ;
      endcase
    end
  end

  assign mm_s_rdata_o = rdata_c;

endmodule
